// File: rtl/sdram_init_ctrl.sv
// rtl/sdram_init_ctrl.sv - SDR SDRAM power-up init sequencer (PRE, AREF x N, LMR).
// SDRAM_INIT_FAST_SIM_EN shortens the power-up wait to 200 cycles.
module sdram_init_ctrl #(
    parameter int          T_POWER  = 20000,
    parameter int          T_RP     = 2,
    parameter int          T_RC     = 7,
    parameter int          T_MRD    = 3,
    parameter int          AREF_NUM = 8,
    parameter logic [12:0] MODE_VAL = 13'h037
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    output logic [3:0]  init_cmd_o,
    output logic [1:0]  init_ba_o,
    output logic [12:0] init_addr_o,
    output logic        init_end_o
);

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int PWR_CYC = 200;
`else
    localparam int PWR_CYC = T_POWER;
`endif
    localparam int CNT_MAX = (T_POWER > 200) ? T_POWER : 200;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ARW     = $clog2(AREF_NUM + 1);

    // The command cycle and the first wait cycle together cover two clocks of each spacing.
    localparam logic [CNT_W-1:0] PWR_END  = CNT_W'(PWR_CYC);
    localparam logic [CNT_W-1:0] TRP_END  = CNT_W'((T_RP  > 2) ? T_RP  - 2 : 0);
    localparam logic [CNT_W-1:0] TRC_END  = CNT_W'((T_RC  > 2) ? T_RC  - 2 : 0);
    localparam logic [CNT_W-1:0] TMRD_END = CNT_W'((T_MRD > 2) ? T_MRD - 2 : 0);
    localparam logic [ARW-1:0]   AREF_MAX = ARW'(AREF_NUM);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [2:0] {
        WAIT_PWR, PRE, WAIT_TRP, AREF, WAIT_TRC, LMR, WAIT_TMRD, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ARW-1:0]   aref_q, aref_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [1:0]       ba_q, ba_d;
    logic [12:0]      addr_q, addr_d;
    logic             end_q, end_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        aref_d  = aref_q;
        case (state_q)
            WAIT_PWR:  if (cnt_q == PWR_END) state_d = PRE;
            PRE:       state_d = WAIT_TRP;
            WAIT_TRP:  if (cnt_q == TRP_END) state_d = AREF;
            AREF: begin
                state_d = WAIT_TRC;
                aref_d  = aref_q + ARW'(1);
            end
            WAIT_TRC:  if (cnt_q == TRC_END) state_d = (aref_q < AREF_MAX) ? AREF : LMR;
            LMR:       state_d = WAIT_TMRD;
            WAIT_TMRD: if (cnt_q == TMRD_END) state_d = DONE;
            default:   state_d = DONE;
        endcase
        if (state_q == DONE) begin
            cnt_d = cnt_q;
        end else if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs follow the state being entered so every command is registered.
        cmd_d  = CMD_NOP;
        ba_d   = 2'b11;
        addr_d = 13'h1FFF;
        end_d  = 1'b0;
        case (state_d)
            PRE:  cmd_d = CMD_PRE;
            AREF: cmd_d = CMD_AREF;
            LMR: begin
                cmd_d  = CMD_LMR;
                ba_d   = 2'b00;
                addr_d = MODE_VAL;
            end
            DONE: end_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_PWR;
            cnt_q   <= '0;
            aref_q  <= '0;
            cmd_q   <= CMD_NOP;
            ba_q    <= 2'b11;
            addr_q  <= 13'h1FFF;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aref_q  <= aref_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
        end
    end

    assign init_cmd_o  = cmd_q;
    assign init_ba_o   = ba_q;
    assign init_addr_o = addr_q;
    assign init_end_o  = end_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// tb/tb_sdram_init_ctrl.sv - randomized reset/abort bench against a schedule-based model.
module tb_sdram_init_ctrl;

    localparam int          T_POWER  = 20000;
    localparam int          T_RP     = 2;
    localparam int          T_RC     = 7;
    localparam int          T_MRD    = 3;
    localparam int          AREF_NUM = 8;
    localparam logic [12:0] MODE_VAL = 13'h037;
`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int TP = 200;
`else
    localparam int TP = T_POWER;
`endif
    localparam int LMR_CYC = TP + T_RP + AREF_NUM * T_RC;
    localparam int END_CYC = LMR_CYC + T_MRD;

    logic        sys_clk_i = 1'b0;
    logic        rst_i     = 1'b1;
    logic [3:0]  init_cmd_o;
    logic [1:0]  init_ba_o;
    logic [12:0] init_addr_o;
    logic        init_end_o;

    int cyc      = -1;
    int nonnop   = 0;
    int n_checks = 0;
    int n_errors = 0;

    sdram_init_ctrl #(
        .T_POWER(T_POWER), .T_RP(T_RP), .T_RC(T_RC), .T_MRD(T_MRD),
        .AREF_NUM(AREF_NUM), .MODE_VAL(MODE_VAL)
    ) dut (
        .sys_clk_i  (sys_clk_i),
        .rst_i      (rst_i),
        .init_cmd_o (init_cmd_o),
        .init_ba_o  (init_ba_o),
        .init_addr_o(init_addr_o),
        .init_end_o (init_end_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [3:0] exp_cmd(input int c);
        if (c == TP) return 4'b0010;
        for (int k = 0; k < AREF_NUM; k++)
            if (c == TP + T_RP + k * T_RC) return 4'b0001;
        if (c == LMR_CYC) return 4'b0000;
        return 4'b0111;
    endfunction

    task automatic compare_all();
        logic [3:0]  ec;
        logic [1:0]  eb;
        logic [12:0] ea;
        logic        ee;
        ec = (cyc < 0) ? 4'b0111 : exp_cmd(cyc);
        eb = (ec == 4'b0000) ? 2'b00 : 2'b11;
        ea = (ec == 4'b0000) ? MODE_VAL : 13'h1FFF;
        ee = (cyc >= END_CYC);
        check("cmd",  32'(init_cmd_o),  32'(ec));
        check("ba",   32'(init_ba_o),   32'(eb));
        check("addr", 32'(init_addr_o), 32'(ea));
        check("end",  32'(init_end_o),  32'(ee));
        if (cyc < 0) nonnop = 0;
        else if (init_cmd_o !== 4'b0111) nonnop++;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk_i);
            if (rst_i) cyc = -1;
            else       cyc++;
            @(negedge sys_clk_i);
            compare_all();
        end
    endtask

    initial begin
        int abort_cyc;
        run_cycles(3 + int'($urandom_range(0, 4)));
        rst_i = 1'b0;

        abort_cyc = TP + T_RP + int'($urandom_range(0, AREF_NUM * T_RC - 1));
        run_cycles(abort_cyc + 1);
        rst_i = 1'b1;
        run_cycles(3);
        rst_i = 1'b0;

        run_cycles(END_CYC + 1 + 1000);
        check("nonnop_count_1", 32'(nonnop), 32'(AREF_NUM + 2));

        rst_i = 1'b1;
        run_cycles(int'($urandom_range(1, 3)));
        rst_i = 1'b0;
        run_cycles(END_CYC + 1 + 50);
        check("nonnop_count_2", 32'(nonnop), 32'(AREF_NUM + 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
